wb_gpio_bridge: RTL and testbench
=================================

# wb_gpio_bridge

Wishbone B4 classic responder that acts as the initiator on the simple GPIO register bus (addr/we/wdata/rdata). It sits between the NoC/RV32I Wishbone interconnect and a GPIO register block. It converts each Wishbone transaction into a register-bus read or write. Byte-select writes are handled by read-modify-write, and errors are flagged for illegal accesses.

## Interface
- ADDR_W, 32, width of wb_adr_i; only bits [3:2] are decoded, and base matching is done by the interconnect.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  1 = write, 0 = read.
- wb_adr_i  in  ADDR_W  byte address; register index = wb_adr_i[3:2].
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte enables; bit n covers bits [8n+7:8n].
- wb_dat_o  out  32  read data, registered, valid while wb_ack_o=1.
- wb_ack_o  out  1  single-cycle acknowledge.
- wb_err_o  out  1  single-cycle error; mutually exclusive with wb_ack_o.
- reg_addr  out  2  register index to the GPIO block (0 = DIR, 1 = OUT, 2 = IN).
- reg_we  out  1  write strobe, one cycle per write.
- reg_wdata  out  32  merged write data.
- reg_rdata  in  32  combinational read data for reg_addr.

## Operation
- The block has four states: IDLE, SETUP, WRITE, RESP.
- IDLE
  - When wb_cyc_i & wb_stb_i, latch idx = wb_adr_i[3:2], we, dat, and sel, then go to SETUP.
  - Otherwise stay in IDLE.
- SETUP
  - reg_addr = idx and reg_we = 0.
  - Read:
    - idx in 0..2: capture reg_rdata into wb_dat_o and set resp = ACK.
    - idx = 3: set wb_dat_o = 0 and resp = ERR.
    - Go to RESP.
  - Write:
    - idx = 2 (IN is read-only) or idx = 3: set resp = ERR and go to RESP. No write occurs.
    - sel = 4'b0000: set resp = ACK and go to RESP. No reg_we pulse occurs.
    - Otherwise: merged = (reg_rdata & ~mask) | (dat & mask), where mask expands sel to 32 bits. Register merged into reg_wdata and go to WRITE.
- WRITE: reg_we = 1 for exactly one cycle with reg_addr = idx and reg_wdata = merged. Set resp = ACK and go to RESP.
- RESP
  - If wb_cyc_i = 1, assert wb_ack_o or wb_err_o according to resp for one cycle.
  - Always return to IDLE.
- A new request seen in IDLE on the cycle after RESP is a new transaction; back-to-back accesses are supported.
- Abort: if wb_cyc_i drops in SETUP, return to IDLE with no write and no response. A WRITE already entered completes its reg_we pulse, and the response is then suppressed.
- reg_addr holds the last idx outside transactions. reg_wdata holds its last value.
- wb_dat_o is cleared to 0 on every write response and every error response.

## Timing
- Reset values: state = IDLE; wb_dat_o = 0; wb_ack_o = 0; wb_err_o = 0; reg_addr = 0; reg_we = 0; reg_wdata = 0.
- Reset is asynchronous and effective mid-transaction. An in-flight access is dropped, and no reg_we pulse is issued after reset asserts.
- Let request-sampled = cycle 0 (IDLE sees stb).
- Read: SETUP in cycle 1, ack in cycle 2. Latency is 2 cycles.
- Full or partial write: SETUP in cycle 1, reg_we in cycle 2, ack in cycle 3. Latency is 3 cycles.
- Error responses and sel = 0 writes: response in cycle 2.
- All outputs are registered, so there is no combinational path from wb_* inputs to wb_* outputs.
- reg_rdata is sampled only in SETUP. The GPIO block must present reg_rdata within the same cycle it sees reg_addr.
- Maximum throughput is one read per 3 cycles (IDLE, SETUP, RESP) and one write per 4 cycles.

## Test plan
- Reset, then full write: write idx 0 with sel = F and dat = 0x0000_00FF -> reg_we pulses once in cycle 2 with reg_addr = 0 and reg_wdata = 0x0000_00FF. Ack follows in cycle 3. A read of idx 0 then returns 0x0000_00FF with ack at latency 2.
- Partial write (RMW): OUT = 0x1234_5678; write idx 1 with sel = 4'b0010 and dat = 0xAAAA_AAAA -> reg_wdata = 0x1234_AA78, one reg_we pulse, then ack.
- Illegal accesses:
  - Write idx 2 -> err in cycle 2, reg_we never asserts.
  - Read idx 3 -> err, wb_dat_o = 0.
  - Write with sel = 0 -> ack in cycle 2, no reg_we.
- Back-to-back: read idx 2, then immediately read idx 1 with stb held -> two acks 3 cycles apart. Each wb_dat_o matches reg_rdata for its index.
- Abort and reset:
  - Drop wb_cyc_i in SETUP of a write -> no reg_we, no ack, FSM back in IDLE.
  - Assert rst during SETUP of a write -> all outputs 0 immediately, and no reg_we afterward.
- GPIO integration: write DIR = 0x0000_000F, then OUT = 0x0000_0005 -> pins[3:0] = 0101 and pins[31:4] = Z. Driving pins[7:4] = 1010 externally, a read of IN then returns 0xA5 in bits [7:0].

Source files
------------

// File: rtl/wb_gpio_bridge.sv
// wb_gpio_bridge: Wishbone B4 classic responder that turns each Wishbone access into a
// read or write on a simple GPIO register bus (addr/we/wdata/rdata).
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   wb_cyc_i/stb_i  Wishbone cycle/strobe
//   wb_we_i         1 = write, 0 = read
//   wb_adr_i        byte address; only [3:2] are decoded (0 = DIR, 1 = OUT, 2 = IN, 3 = none)
//   wb_dat_i/sel_i  write data and byte enables
//   wb_dat_o        registered read data, valid while wb_ack_o is high
//   wb_ack_o/err_o  single-cycle, mutually exclusive responses
//   reg_addr        register index to the GPIO block
//   reg_we          one-cycle write strobe
//   reg_wdata       merged write data
//   reg_rdata       combinational read data for reg_addr
//
// Partial writes read the target register in SETUP and merge the unselected bytes back in,
// so every register-bus write is a full 32-bit word.
module wb_gpio_bridge #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  input  logic [3:0]        wb_sel_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic [1:0]        reg_addr,
  output logic              reg_we,
  output logic [31:0]       reg_wdata,
  input  logic [31:0]       reg_rdata
);

  typedef enum logic [1:0] {StIdle, StSetup, StWrite, StResp} state_e;

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;       // doubles as reg_addr, so it holds between transactions
  logic        we_q, we_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wb_dat_q, wb_dat_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic        reg_we_q, reg_we_d;
  logic [31:0] reg_wdata_q, reg_wdata_d;

  logic [31:0] mask;
  logic [31:0] merged;

  // Base matching happens in the interconnect; the remaining address bits are ignored.
  logic unused_adr;
  assign unused_adr = ^{wb_adr_i[ADDR_W-1:4], wb_adr_i[1:0]};

  always_comb begin
    mask = '0;
    for (int b = 0; b < 4; b++) begin
      mask[8*b +: 8] = {8{sel_q[b]}};
    end
  end

  assign merged = (reg_rdata & ~mask) | (dat_q & mask);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    we_d        = we_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    wb_dat_d    = wb_dat_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    reg_we_d    = 1'b0;
    reg_wdata_d = reg_wdata_q;

    unique case (state_q)
      StIdle: begin
        if (wb_cyc_i && wb_stb_i) begin
          idx_d   = wb_adr_i[3:2];
          we_d    = wb_we_i;
          dat_d   = wb_dat_i;
          sel_d   = wb_sel_i;
          state_d = StSetup;
        end
      end

      StSetup: begin
        if (!wb_cyc_i) begin
          // Master abandoned the cycle: no write, no response.
          state_d = StIdle;
        end else if (!we_q) begin
          state_d = StResp;
          if (idx_q == 2'd3) begin
            err_d    = 1'b1;
            wb_dat_d = '0;
          end else begin
            ack_d    = 1'b1;
            wb_dat_d = reg_rdata;
          end
        end else if (idx_q[1]) begin
          // IN is read-only and index 3 is unmapped.
          state_d  = StResp;
          err_d    = 1'b1;
          wb_dat_d = '0;
        end else if (sel_q == 4'b0000) begin
          state_d  = StResp;
          ack_d    = 1'b1;
          wb_dat_d = '0;
        end else begin
          state_d     = StWrite;
          reg_we_d    = 1'b1;
          reg_wdata_d = merged;
        end
      end

      StWrite: begin
        // The write strobe is already out; only the response depends on the master staying.
        state_d = StResp;
        if (wb_cyc_i) begin
          ack_d    = 1'b1;
          wb_dat_d = '0;
        end
      end

      StResp: begin
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      idx_q       <= 2'd0;
      we_q        <= 1'b0;
      dat_q       <= '0;
      sel_q       <= '0;
      wb_dat_q    <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      reg_we_q    <= 1'b0;
      reg_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      we_q        <= we_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      wb_dat_q    <= wb_dat_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      reg_we_q    <= reg_we_d;
      reg_wdata_q <= reg_wdata_d;
    end
  end

  assign wb_dat_o  = wb_dat_q;
  assign wb_ack_o  = ack_q;
  assign wb_err_o  = err_q;
  assign reg_addr  = idx_q;
  assign reg_we    = reg_we_q;
  assign reg_wdata = reg_wdata_q;

endmodule

// File: tb/tb_wb_gpio_bridge.sv
// Testbench for wb_gpio_bridge: a small GPIO register block sits on the register bus,
// and every Wishbone access is checked against a register-level model of DIR/OUT/IN.
module tb_wb_gpio_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [31:0] wb_adr_i, wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o;
  logic [1:0]  reg_addr;
  logic        reg_we;
  logic [31:0] reg_wdata, reg_rdata;

  always #5 clk = ~clk;

  wb_gpio_bridge #(.ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_cyc_i  (wb_cyc_i),
    .wb_stb_i  (wb_stb_i),
    .wb_we_i   (wb_we_i),
    .wb_adr_i  (wb_adr_i),
    .wb_dat_i  (wb_dat_i),
    .wb_sel_i  (wb_sel_i),
    .wb_dat_o  (wb_dat_o),
    .wb_ack_o  (wb_ack_o),
    .wb_err_o  (wb_err_o),
    .reg_addr  (reg_addr),
    .reg_we    (reg_we),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata)
  );

  // GPIO block on the register bus; a pin is driven by OUT where DIR=1, else by ext_pins.
  logic [31:0] gpio_dir_q, gpio_out_q, ext_pins, pins_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpio_dir_q <= '0;
      gpio_out_q <= '0;
    end else if (reg_we) begin
      if (reg_addr == 2'd0) gpio_dir_q <= reg_wdata;
      if (reg_addr == 2'd1) gpio_out_q <= reg_wdata;
    end
  end

  assign pins_in = (gpio_out_q & gpio_dir_q) | (ext_pins & ~gpio_dir_q);

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      2'd0: reg_rdata = gpio_dir_q;
      2'd1: reg_rdata = gpio_out_q;
      2'd2: reg_rdata = pins_in;
      default: reg_rdata = '0;
    endcase
  end

  int we_total = 0;
  always @(posedge clk) if (reg_we) we_total <= we_total + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: register contents at the register level.
  logic [31:0] m_dir = '0;
  logic [31:0] m_out = '0;

  logic        l_ack, l_err;
  logic [31:0] l_rdat, l_wdata;
  logic [1:0]  l_waddr;
  int          l_lat, l_nwe;

  task automatic drive_req(input logic we, input logic [1:0] idx, input logic [31:0] dat,
                           input logic [3:0] sel);
    logic [31:0] r;
    r = $urandom();
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = {r[31:4], idx, r[1:0]};
    wb_dat_i = dat;
    wb_sel_i = sel;
  endtask

  task automatic idle_bus();
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  // Cycle k after the request is observed at the k-th falling edge after driving it.
  task automatic wb_xfer(input logic we, input logic [1:0] idx, input logic [31:0] dat,
                         input logic [3:0] sel);
    @(negedge clk);
    drive_req(we, idx, dat, sel);
    l_ack = 0; l_err = 0; l_rdat = '0; l_lat = 99; l_nwe = 0; l_waddr = '0; l_wdata = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (reg_we) begin
        l_nwe++;
        l_waddr = reg_addr;
        l_wdata = reg_wdata;
      end
      if (wb_ack_o || wb_err_o) begin
        l_ack = wb_ack_o;
        l_err = wb_err_o;
        l_rdat = wb_dat_o;
        l_lat = k;
        break;
      end
    end
    idle_bus();
  endtask

  task automatic run(input logic we, input logic [1:0] idx, input logic [31:0] dat,
                     input logic [3:0] sel, input string tag);
    logic        eack, eerr;
    logic [31:0] erdat, ewdata, old;
    int          elat, enwe;
    eack = 0; eerr = 0; erdat = '0; ewdata = '0; elat = 2; enwe = 0;
    if (!we) begin
      if (idx == 2'd3) eerr = 1;
      else begin
        eack = 1;
        if (idx == 2'd0)      erdat = m_dir;
        else if (idx == 2'd1) erdat = m_out;
        else                  erdat = (m_out & m_dir) | (ext_pins & ~m_dir);
      end
    end else if (idx >= 2'd2) begin
      eerr = 1;
    end else if (sel == 4'b0000) begin
      eack = 1;
    end else begin
      eack = 1; elat = 3; enwe = 1;
      old = (idx == 2'd0) ? m_dir : m_out;
      for (int b = 0; b < 4; b++) ewdata[8*b +: 8] = sel[b] ? dat[8*b +: 8] : old[8*b +: 8];
    end

    wb_xfer(we, idx, dat, sel);

    check({tag, " resp"}, {30'b0, l_ack, l_err}, {30'b0, eack, eerr});
    check({tag, " latency"}, l_lat, elat);
    check({tag, " dat_o"}, l_rdat, erdat);
    check({tag, " we_pulses"}, l_nwe, enwe);
    if (enwe == 1) begin
      check({tag, " reg_addr"}, {30'b0, l_waddr}, {30'b0, idx});
      check({tag, " reg_wdata"}, l_wdata, ewdata);
      if (idx == 2'd0) m_dir = ewdata;
      else             m_out = ewdata;
    end
  endtask

  initial begin
    int   t0, t1, we0, saw;
    logic [31:0] exp_in;
    rst = 1'b0;
    ext_pins = '0;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
    idle_bus();
    repeat (3) @(negedge clk);
    check("rst dat_o", wb_dat_o, 32'h0);
    check("rst ctl", {27'b0, wb_ack_o, wb_err_o, reg_we, reg_addr}, 32'h0);
    check("rst wdata", reg_wdata, 32'h0);
    rst = 1'b1;

    // Directed cases.
    run(1'b1, 2'd0, 32'h0000_00FF, 4'hF, "wr_dir");
    check("wr_dir literal", l_wdata, 32'h0000_00FF);
    run(1'b0, 2'd0, 32'h0, 4'hF, "rd_dir");
    check("rd_dir literal", l_rdat, 32'h0000_00FF);
    run(1'b1, 2'd1, 32'h1234_5678, 4'hF, "wr_out");
    run(1'b1, 2'd1, 32'hAAAA_AAAA, 4'b0010, "rmw");
    check("rmw literal", l_wdata, 32'h1234_AA78);
    run(1'b1, 2'd2, 32'hDEAD_BEEF, 4'hF, "wr_in");
    run(1'b0, 2'd3, 32'h0, 4'hF, "rd_3");
    run(1'b1, 2'd3, 32'h5555_5555, 4'hF, "wr_3");
    run(1'b1, 2'd0, 32'hFFFF_FFFF, 4'h0, "sel0");

    // Back-to-back reads with stb held between them.
    ext_pins = $urandom();
    exp_in = (m_out & m_dir) | (ext_pins & ~m_dir);
    t0 = -1; t1 = -1;
    @(negedge clk);
    drive_req(1'b0, 2'd2, 32'h0, 4'hF);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (wb_ack_o) begin
        if (t0 < 0) begin
          t0 = k;
          check("b2b first dat", wb_dat_o, exp_in);
          drive_req(1'b0, 2'd1, 32'h0, 4'hF);
        end else begin
          t1 = k;
          check("b2b second dat", wb_dat_o, m_out);
          break;
        end
      end
    end
    idle_bus();
    check("b2b first lat", t0, 2);
    check("b2b spacing", t1 - t0, 3);

    // Abort: master drops cyc while the bridge is in SETUP of a write.
    we0 = we_total; saw = 0;
    @(negedge clk);
    drive_req(1'b1, 2'd1, 32'hFFFF_FFFF, 4'hF);
    @(negedge clk);
    idle_bus();
    repeat (5) begin
      @(negedge clk);
      if (wb_ack_o || wb_err_o || reg_we) saw++;
    end
    check("abort we", we_total - we0, 0);
    check("abort resp", saw, 0);
    run(1'b0, 2'd1, 32'h0, 4'hF, "post_abort");

    // Reset while a write sits in SETUP.
    we0 = we_total;
    @(negedge clk);
    drive_req(1'b1, 2'd0, 32'hCAFE_F00D, 4'hF);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst ctl", {27'b0, wb_ack_o, wb_err_o, reg_we, reg_addr}, 32'h0);
    check("midrst dat_o", wb_dat_o, 32'h0);
    check("midrst wdata", reg_wdata, 32'h0);
    idle_bus();
    m_dir = '0; m_out = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst we", we_total - we0, 0);

    // GPIO integration.
    run(1'b1, 2'd0, 32'h0000_000F, 4'hF, "int_dir");
    run(1'b1, 2'd1, 32'h0000_0005, 4'hF, "int_out");
    check("pins lo", {28'b0, pins_in[3:0]}, 32'h5);
    check("pins hi undriven", gpio_dir_q & 32'hFFFF_FFF0, 32'h0);
    ext_pins = 32'h0000_00A0;
    run(1'b0, 2'd2, 32'h0, 4'hF, "int_in");
    check("int_in literal", l_rdat, 32'h0000_00A5);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      logic [3:0] s;
      int r;
      r = $urandom_range(0, 3);
      s = (r == 0) ? 4'h0 : (r == 1) ? 4'hF : 4'($urandom());
      ext_pins = $urandom();
      run(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom(), s, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
